lsu_mem_port: RTL

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 30 +++
 rtl/lsu_mem_port.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory port: funct3 size codes,
// FSM states and store byte-enable base patterns.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Size is carried in funct3[1:0]; funct3[2] only selects zero-extension.
  function automatic logic [7:0] be_base(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   be_base = BE_B;
      2'b01:   be_base = BE_H;
      2'b10:   be_base = BE_W;
      default: be_base = BE_D;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte lane of a memory word and sign/zero-extends
// it according to the load size code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] rdata,
  output logic [63:0] data
);

  logic [63:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{56{lane[7]}},  lane[7:0]};
      F3_H:    data = {{48{lane[15]}}, lane[15:0]};
      F3_W:    data = {{32{lane[31]}}, lane[31:0]};
      F3_D:    data = lane;
      F3_BU:   data = {56'd0, lane[7:0]};
      F3_HU:   data = {48'd0, lane[15:0]};
      F3_WU:   data = {32'd0, lane[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port between a core and a 64-bit-word
// synchronous memory with byte write enables; all outputs are registered.
//
// state   | meaning
// S_IDLE  | req_ready high, waiting for a request
// S_ISSUE | one-cycle memory access (mem_re or mem_we)
// S_WAIT  | load data returning from memory, captured and aligned
// S_RESP  | one-cycle resp_valid pulse
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [63:0]           req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [7:0]            mem_we,
  output logic                  mem_re,
  input  logic [WIDTH-1:0]      mem_rdata
);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [2:0]  offset_q;
  logic        accept, req_illegal, req_misaligned, fault;
  logic [63:0] load_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[63:ADDR_WIDTH+3];

  assign accept      = (state_q == S_IDLE) && req_ready && req_valid;
  assign req_illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      2'b11:   req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  assign fault = req_illegal || req_misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = fault ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  lsu_load_align u_align (
    .funct3 (funct3_q),
    .offset (offset_q),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  // Outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      we_q            <= 1'b0;
      funct3_q        <= '0;
      offset_q        <= '0;
      req_ready       <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_we          <= '0;
      mem_re          <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_ready  <= (state_d == S_IDLE);
      resp_valid <= (state_d == S_RESP);
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= '0;
      mem_re     <= 1'b0;
      if (state_d != S_RESP) begin
        resp_rdata      <= '0;
        resp_misaligned <= 1'b0;
        resp_illegal    <= 1'b0;
      end
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        offset_q <= req_addr[2:0];
        if (fault) begin
          resp_illegal    <= req_illegal;
          resp_misaligned <= !req_illegal && req_misaligned;
        end else begin
          mem_addr <= req_addr[ADDR_WIDTH+2:3];
          if (req_we) begin
            mem_we    <= 8'(be_base(req_funct3) << req_addr[2:0]);
            mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
          end else begin
            mem_re <= 1'b1;
          end
        end
      end
      if (state_q == S_WAIT) resp_rdata <= load_data;
    end
  end

endmodule
